// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared command codes, types and FSM states for the keyboard sequencer
package kbd_pkg;

    typedef logic [2:0] instr_t;

    localparam instr_t CMD_CLRLD = 3'b000;
    localparam instr_t CMD_ADD   = 3'b001;
    localparam instr_t CMD_SUB   = 3'b010;
    localparam instr_t CMD_DISP  = 3'b011;
    localparam instr_t CMD_LOAD  = 3'b100;
    localparam instr_t CMD_NOP   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DISPLAY
    } state_e;

    // NOP and the unused codes above LOAD carry no work and are never queued
    function automatic logic is_enqueueable(input instr_t code);
        return code <= CMD_LOAD;
    endfunction

endpackage

// File: rtl/kbd_cmd_fifo.sv
// rtl/kbd_cmd_fifo.sv - synchronous command FIFO with flush
module kbd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    // full is judged on the pre-pop count, so a push into a full queue is refused even when popping
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // storage has no reset; only pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // pointer/count update; a flush discards everything queued but keeps a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            wr_ptr_q <= wr_ptr_q + PW'(wr_en);
            count_q  <= CW'(wr_en);
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(wr_en);
            rd_ptr_q <= rd_ptr_q + PW'(rd_en);
            count_q  <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/kbd_instr_sequencer.sv
// rtl/kbd_instr_sequencer.sv - keyboard command capture, queueing and datapath issue
module kbd_instr_sequencer
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DISP_HOLD    = 16,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] kbd_instruction,
    input  logic       kbd_new_instruction,
    output logic       kbd_ready,
    output logic [2:0] dp_cmd,
    output logic       dp_cmd_valid,
    input  logic       dp_cmd_ready,
    input  logic       dp_done,
    output logic       disp_en,
    output logic       busy,
    output logic       err_overflow,
    output logic       err_timeout,
    input  logic       err_clr
);

    localparam int TMAX = (DISP_HOLD > DONE_TIMEOUT) ? DISP_HOLD : DONE_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] DISP_LAST    = TW'(DISP_HOLD - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DONE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rise;
    logic                   cap_valid;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    instr_t                 fifo_rdata;
    logic                   overflow_evt;
    logic                   timeout_evt;

    state_e        state_q, state_d;
    instr_t        cmd_q, cmd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dp_cmd_valid_q, dp_cmd_valid_d;
    logic          disp_en_q, disp_en_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_timeout_q, err_timeout_d;

    // bring the asynchronous strobe into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], kbd_new_instruction};
        end
    end

    // edge taken across the last two stages so the FIFO write lands on edge SYNC_STAGES
    assign rise         = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign cap_valid    = rise & is_enqueueable(kbd_instruction);
    assign fifo_push    = cap_valid & ~fifo_full;
    assign fifo_flush   = fifo_push & (kbd_instruction == CMD_CLRLD);
    assign overflow_evt = cap_valid & fifo_full;

    kbd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (kbd_instruction),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // issue FSM: next state, timers, registered output values and sticky errors
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        timer_d     = timer_q;
        fifo_pop    = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dp_cmd_ready) begin
                    timer_d = '0;
                    state_d = (cmd_q == CMD_DISP) ? ST_DISPLAY : ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (dp_done) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DISPLAY: begin
                if (timer_q == DISP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        dp_cmd_valid_d = (state_d == ST_ISSUE);
        disp_en_d      = (state_d == ST_DISPLAY);
        err_overflow_d = overflow_evt | (err_overflow_q & ~err_clr);
        err_timeout_d  = timeout_evt | (err_timeout_q & ~err_clr);
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cmd_q          <= CMD_CLRLD;
            timer_q        <= '0;
            dp_cmd_valid_q <= 1'b0;
            disp_en_q      <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            timer_q        <= timer_d;
            dp_cmd_valid_q <= dp_cmd_valid_d;
            disp_en_q      <= disp_en_d;
            err_overflow_q <= err_overflow_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign dp_cmd       = cmd_q;
    assign dp_cmd_valid = dp_cmd_valid_q;
    assign disp_en      = disp_en_q;
    assign err_overflow = err_overflow_q;
    assign err_timeout  = err_timeout_q;
    assign kbd_ready    = ~fifo_full;
    assign busy         = (state_q != ST_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_kbd_instr_sequencer.sv
// tb/tb_kbd_instr_sequencer.sv - scoreboard bench for the keyboard command sequencer
module tb_kbd_instr_sequencer;
    import kbd_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] kbd_instruction;
    logic       kbd_new_instruction;
    logic       kbd_ready;
    logic [2:0] dp_cmd;
    logic       dp_cmd_valid;
    logic       dp_cmd_ready;
    logic       dp_done;
    logic       disp_en;
    logic       busy;
    logic       err_overflow;
    logic       err_timeout;
    logic       err_clr;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] exp_q[$];
    bit         auto_done = 1'b1;

    kbd_instr_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .kbd_instruction     (kbd_instruction),
        .kbd_new_instruction (kbd_new_instruction),
        .kbd_ready           (kbd_ready),
        .dp_cmd              (dp_cmd),
        .dp_cmd_valid        (dp_cmd_valid),
        .dp_cmd_ready        (dp_cmd_ready),
        .dp_done             (dp_done),
        .disp_en             (disp_en),
        .busy                (busy),
        .err_overflow        (err_overflow),
        .err_timeout         (err_timeout),
        .err_clr             (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] code, input bit expect_issue);
        if (expect_issue) exp_q.push_back(code);
        kbd_instruction     = code;
        kbd_new_instruction = 1'b1;
        repeat (3) tick();
        kbd_new_instruction = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dp_cmd_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(dp_cmd_valid), 1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) tick();
        check_eq(tag, exp_q.size(), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    // scoreboard: every handshake must match the next expected command
    always @(negedge clk) begin
        if (rst_n && dp_cmd_valid && dp_cmd_ready) begin
            check_eq("issue_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("dp_cmd", 32'(dp_cmd), 32'(exp_q.pop_front()));
        end
    end

    // datapath model: completes non-DISP commands three cycles after acceptance
    initial begin
        dp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_done && rst_n && dp_cmd_valid && dp_cmd_ready && dp_cmd != CMD_DISP) begin
                repeat (3) @(posedge clk);
                #1 dp_done = 1'b1;
                @(posedge clk);
                #1 dp_done = 1'b0;
            end
        end
    end

    initial begin
        logic [2:0] head;
        bit         stable;
        int         hi;
        int         vcnt;
        int         n;

        rst_n               = 1'b0;
        kbd_instruction     = CMD_CLRLD;
        kbd_new_instruction = 1'b0;
        dp_cmd_ready        = 1'b0;
        err_clr             = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 32'(dp_cmd_valid), 0);
        check_eq("rst_cmd", 32'(dp_cmd), 0);
        check_eq("rst_disp", 32'(disp_en), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ovf", 32'(err_overflow), 0);
        check_eq("rst_tmo", 32'(err_timeout), 0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_kbd_ready", 32'(kbd_ready), 1);

        // latency: edge 2 writes, edge 3 pops and raises valid
        dp_cmd_ready = 1'b1;
        exp_q.push_back(CMD_ADD);
        kbd_instruction     = CMD_ADD;
        kbd_new_instruction = 1'b1;
        tick();
        tick();
        check_eq("lat_e2_valid", 32'(dp_cmd_valid), 0);
        tick();
        check_eq("lat_e3_valid", 32'(dp_cmd_valid), 1);
        check_eq("lat_e3_cmd", 32'(dp_cmd), 32'(CMD_ADD));
        kbd_new_instruction = 1'b0;
        tick();
        check_eq("lat_e4_valid", 32'(dp_cmd_valid), 0);
        check_eq("lat_e4_busy", 32'(busy), 1);
        repeat (6) tick();
        check_eq("lat_done_busy", 32'(busy), 0);
        dp_cmd_ready = 1'b0;

        // stalled datapath holds valid and cmd stable
        send(CMD_ADD, 1'b1);
        wait_valid("stall_valid");
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!dp_cmd_valid || dp_cmd != CMD_ADD) stable = 1'b0;
        end
        check_eq("stall_stable", 32'(stable), 1);
        dp_cmd_ready = 1'b1;
        tick();
        check_eq("stall_hs_valid", 32'(dp_cmd_valid), 0);
        dp_cmd_ready = 1'b0;
        drain("stall_drain");

        // CLRLD flushes queued SUB/LOAD; in-flight ADD still completes
        send(CMD_ADD, 1'b1);
        wait_valid("clr_valid");
        send(CMD_SUB, 1'b1);
        send(CMD_LOAD, 1'b1);
        head = exp_q[0];
        exp_q.delete();
        exp_q.push_back(head);
        send(CMD_CLRLD, 1'b1);
        dp_cmd_ready = 1'b1;
        drain("clr_drain");
        dp_cmd_ready = 1'b0;

        // discarded codes never enter the queue
        send(CMD_NOP, 1'b0);
        send(3'b110, 1'b0);
        send(3'b111, 1'b0);
        check_eq("discard_busy", 32'(busy), 0);
        check_eq("discard_valid", 32'(dp_cmd_valid), 0);

        // overflow: one in flight, four queued, fifth dropped
        send(CMD_ADD, 1'b1);
        wait_valid("ovf_valid");
        send(CMD_SUB, 1'b1);
        send(CMD_LOAD, 1'b1);
        send(CMD_ADD, 1'b1);
        check_eq("ovf_ready_3", 32'(kbd_ready), 1);
        send(CMD_SUB, 1'b1);
        check_eq("ovf_ready_4", 32'(kbd_ready), 0);
        check_eq("ovf_err_4", 32'(err_overflow), 0);
        send(CMD_LOAD, 1'b0);
        check_eq("ovf_err_5", 32'(err_overflow), 1);
        check_eq("ovf_ready_5", 32'(kbd_ready), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("ovf_clr", 32'(err_overflow), 0);
        dp_cmd_ready = 1'b1;
        drain("ovf_drain");
        dp_cmd_ready = 1'b0;

        // DISP: 16-cycle window, single-cycle valid, no done wait
        dp_cmd_ready = 1'b1;
        exp_q.push_back(CMD_DISP);
        kbd_instruction     = CMD_DISP;
        kbd_new_instruction = 1'b1;
        hi   = 0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 2) kbd_new_instruction = 1'b0;
            hi   += int'(disp_en);
            vcnt += int'(dp_cmd_valid);
        end
        check_eq("disp_cycles", hi, 16);
        check_eq("disp_valid_cycles", vcnt, 1);
        check_eq("disp_busy", 32'(busy), 0);

        // timeout after 255 cycles in WAIT_DONE
        auto_done = 1'b0;
        exp_q.push_back(CMD_ADD);
        kbd_instruction     = CMD_ADD;
        kbd_new_instruction = 1'b1;
        repeat (3) tick();
        kbd_new_instruction = 1'b0;
        tick();
        n = 0;
        while (!err_timeout && n < 400) begin
            tick();
            n++;
        end
        check_eq("tmo_cycles", n, 255);
        check_eq("tmo_busy", 32'(busy), 0);
        check_eq("tmo_valid", 32'(dp_cmd_valid), 0);

        // reset while in ISSUE clears everything at once
        dp_cmd_ready        = 1'b0;
        kbd_instruction     = CMD_SUB;
        kbd_new_instruction = 1'b1;
        repeat (3) tick();
        check_eq("mid_issue_valid", 32'(dp_cmd_valid), 1);
        kbd_new_instruction = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(dp_cmd_valid), 0);
        check_eq("mid_rst_cmd", 32'(dp_cmd), 0);
        check_eq("mid_rst_disp", 32'(disp_en), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_tmo", 32'(err_timeout), 0);
        check_eq("mid_rst_ovf", 32'(err_overflow), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("post_rst_valid", 32'(dp_cmd_valid), 0);
        check_eq("post_rst_busy", 32'(busy), 0);
        check_eq("post_rst_kbd_ready", 32'(kbd_ready), 1);
        auto_done = 1'b1;

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
